regfile_sb: RTL and testbench

Parametrised register file with two combinational read ports, one synchronous write port, optional write-to-read bypass and a per-register busy scoreboard. It is the successor of the 8×16 single-read-port register file in the datapath. Issue logic reserves a destination register, and the writeback of that register releases it. Read ports report whether the returned operand is still pending, so the controller can stall without external hazard tracking.

---
 rtl/regfile_sb_if.sv | 33 +++
 rtl/regfile_sb.sv | 80 ++++++++
 tb/tb_regfile_sb.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/regfile_sb_if.sv
// Operand/writeback/reservation bus for regfile_sb.
// Issue/writeback logic drives the master side; the register file is the slave.
interface regfile_sb_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  localparam int NREGS = 1 << ADDR_W;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [DATA_W-1:0] rd_data_a;
  logic              busy_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_b;
  logic              busy_b;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_addr;
  logic              rsv_stall;
  logic [NREGS-1:0]  busy_vec;
  logic [ADDR_W:0]   busy_cnt;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, rsv_en, rsv_addr,
    input  rd_data_a, busy_a, rd_data_b, busy_b, rsv_stall, busy_vec, busy_cnt
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, rsv_en, rsv_addr,
    output rd_data_a, busy_a, rd_data_b, busy_b, rsv_stall, busy_vec, busy_cnt
  );
endinterface

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with optional write bypass and a per-register
// busy scoreboard (reserve at issue, release at writeback) plus a busy counter.
module regfile_sb #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 3,
  parameter bit BYPASS  = 1'b1,
  parameter bit ZERO_R0 = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  regfile_sb_if.slave  bus
);
  localparam int NREGS = 1 << ADDR_W;
  localparam int CW    = ADDR_W + 1;

  logic [NREGS-1:0][DATA_W-1:0] r_regs;
  logic [NREGS-1:0]             r_busy;
  logic [CW-1:0]                r_cnt;

  logic             w_wr_ok, w_rsv_r0, w_same, w_rsv_ok, w_set, w_clr;
  logic [NREGS-1:0] w_busy_nxt;

  assign w_wr_ok       = bus.wr_en & ~(ZERO_R0 && bus.wr_addr == '0);
  assign w_rsv_r0      = ZERO_R0 && bus.rsv_addr == '0;
  assign w_same        = bus.wr_en & (bus.wr_addr == bus.rsv_addr);
  assign bus.rsv_stall = bus.rsv_en & r_busy[bus.rsv_addr] & ~w_same & ~w_rsv_r0;
  assign w_rsv_ok      = bus.rsv_en & ~bus.rsv_stall & ~w_rsv_r0;

  // Counter delta: a reservation that re-arms a register being written is net 0.
  assign w_set = w_rsv_ok & ~r_busy[bus.rsv_addr];
  assign w_clr = w_wr_ok & r_busy[bus.wr_addr] & ~(w_rsv_ok & w_same);

  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wr_ok)  w_busy_nxt[bus.wr_addr]  = 1'b0;
    if (w_rsv_ok) w_busy_nxt[bus.rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_regs <= '0;
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_wr_ok) r_regs[bus.wr_addr] <= bus.wr_data;
      r_busy <= w_busy_nxt;
      r_cnt  <= r_cnt + CW'(w_set) - CW'(w_clr);
    end
  end

  assign bus.busy_vec = r_busy;
  assign bus.busy_cnt = r_cnt;

  logic [ADDR_W-1:0] w_ra [2];
  logic [DATA_W-1:0] w_rd [2];
  logic              w_rb [2];

  assign w_ra[0] = bus.rd_addr_a;
  assign w_ra[1] = bus.rd_addr_b;

  for (genvar gp = 0; gp < 2; gp++) begin : g_rd
    always_comb begin
      w_rd[gp] = r_regs[w_ra[gp]];
      w_rb[gp] = r_busy[w_ra[gp]];
      if (BYPASS && bus.wr_en && bus.wr_addr == w_ra[gp]) begin
        w_rd[gp] = bus.wr_data;
        w_rb[gp] = 1'b0;
      end
      if (ZERO_R0 && w_ra[gp] == '0) begin
        w_rd[gp] = '0;
        w_rb[gp] = 1'b0;
      end
    end
  end

  assign bus.rd_data_a = w_rd[0];
  assign bus.busy_a    = w_rb[0];
  assign bus.rd_data_b = w_rd[1];
  assign bus.busy_b    = w_rb[1];
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: default build (bypass), a no-bypass build and a
// zero-r0 build share clock and reset.
module tb_regfile_sb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  regfile_sb_if #(.DATA_W(16), .ADDR_W(3)) i0 ();
  regfile_sb_if #(.DATA_W(16), .ADDR_W(3)) i1 ();
  regfile_sb_if #(.DATA_W(16), .ADDR_W(3)) i2 ();

  regfile_sb #(.DATA_W(16), .ADDR_W(3), .BYPASS(1'b1), .ZERO_R0(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(i0.slave));
  regfile_sb #(.DATA_W(16), .ADDR_W(3), .BYPASS(1'b0), .ZERO_R0(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(i1.slave));
  regfile_sb #(.DATA_W(16), .ADDR_W(3), .BYPASS(1'b1), .ZERO_R0(1'b1)) dut2 (.clk(clk), .rst(rst), .bus(i2.slave));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    i0.wr_en = 0; i0.rsv_en = 0; i0.wr_addr = 0; i0.wr_data = 0; i0.rsv_addr = 0;
    i1.wr_en = 0; i1.rsv_en = 0; i1.wr_addr = 0; i1.wr_data = 0; i1.rsv_addr = 0;
    i2.wr_en = 0; i2.rsv_en = 0; i2.wr_addr = 0; i2.wr_data = 0; i2.rsv_addr = 0;
    i0.rd_addr_a = 0; i0.rd_addr_b = 0; i1.rd_addr_a = 0; i1.rd_addr_b = 0;
    i2.rd_addr_a = 0; i2.rd_addr_b = 0;
  endtask

  task automatic test_reset();
    for (int a = 0; a < 8; a++) begin
      i0.rd_addr_a = 3'(a); i0.rd_addr_b = 3'(7 - a);
      #1;
      n_chk++; if (i0.rd_data_a !== 16'h0 || i0.busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_port_a[%0d]: got %h/%b want 0000/0", a, i0.rd_data_a, i0.busy_a); end
      n_chk++; if (i0.rd_data_b !== 16'h0 || i0.busy_b !== 1'b0) begin n_fail++; $display("FAIL reset_port_b[%0d]: got %h/%b want 0000/0", 7 - a, i0.rd_data_b, i0.busy_b); end
    end
    n_chk++; if (i0.busy_cnt !== 4'd0 || i0.busy_vec !== 8'h00) begin n_fail++; $display("FAIL reset_busy: got cnt %0d vec %h want 0/00", i0.busy_cnt, i0.busy_vec); end
    n_chk++; if (i0.rsv_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", i0.rsv_stall); end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_write_readback();
    i0.wr_en = 1; i0.wr_addr = 3; i0.wr_data = 16'hA5A5;
    step();
    i0.wr_addr = 7; i0.wr_data = 16'h0F0F;
    step();
    i0.wr_en = 0; i0.rd_addr_a = 3; i0.rd_addr_b = 7;
    #1;
    n_chk++; if (i0.rd_data_a !== 16'hA5A5) begin n_fail++; $display("FAIL wr_rd_r3: got %h want a5a5", i0.rd_data_a); end
    n_chk++; if (i0.rd_data_b !== 16'h0F0F) begin n_fail++; $display("FAIL wr_rd_r7: got %h want 0f0f", i0.rd_data_b); end
    i0.rd_addr_b = 3;
    #1;
    n_chk++; if (i0.rd_data_b !== 16'hA5A5 || i0.rd_data_a !== 16'hA5A5) begin n_fail++; $display("FAIL both_ports_r3: got %h/%h want a5a5/a5a5", i0.rd_data_a, i0.rd_data_b); end
    step();
  endtask

  task automatic test_bypass();
    i0.rsv_en = 1; i0.rsv_addr = 5;
    step();
    i0.rsv_en = 0; i0.rd_addr_a = 5; i1.rd_addr_a = 5;
    #1;
    n_chk++; if (i0.busy_a !== 1'b1) begin n_fail++; $display("FAIL bypass_pre_busy: got %b want 1", i0.busy_a); end
    i0.wr_en = 1; i0.wr_addr = 5; i0.wr_data = 16'h1234;
    i1.wr_en = 1; i1.wr_addr = 5; i1.wr_data = 16'h1234;
    #1;
    n_chk++; if (i0.rd_data_a !== 16'h1234 || i0.busy_a !== 1'b0) begin n_fail++; $display("FAIL bypass_same_cycle: got %h/%b want 1234/0", i0.rd_data_a, i0.busy_a); end
    n_chk++; if (i1.rd_data_a !== 16'h0000) begin n_fail++; $display("FAIL nobypass_old: got %h want 0000", i1.rd_data_a); end
    step();
    i0.wr_en = 0; i1.wr_en = 0;
    #1;
    n_chk++; if (i1.rd_data_a !== 16'h1234) begin n_fail++; $display("FAIL nobypass_next: got %h want 1234", i1.rd_data_a); end
    n_chk++; if (i0.busy_cnt !== 4'd0 || i0.busy_a !== 1'b0) begin n_fail++; $display("FAIL bypass_release: got cnt %0d busy %b want 0/0", i0.busy_cnt, i0.busy_a); end
  endtask

  task automatic test_scoreboard();
    i0.rsv_en = 1; i0.rsv_addr = 2;
    #1;
    n_chk++; if (i0.rsv_stall !== 1'b0) begin n_fail++; $display("FAIL rsv_r2_stall: got %b want 0", i0.rsv_stall); end
    step();
    i0.rsv_addr = 4;
    step();
    i0.rsv_en = 0;
    #1;
    n_chk++; if (i0.busy_cnt !== 4'd2 || i0.busy_vec !== 8'h14) begin n_fail++; $display("FAIL rsv_two: got cnt %0d vec %h want 2/14", i0.busy_cnt, i0.busy_vec); end
    i0.rsv_en = 1; i0.rsv_addr = 2;
    #1;
    n_chk++; if (i0.rsv_stall !== 1'b1) begin n_fail++; $display("FAIL rsv_again_stall: got %b want 1", i0.rsv_stall); end
    step();
    i0.rsv_en = 0;
    #1;
    n_chk++; if (i0.busy_cnt !== 4'd2 || i0.busy_vec !== 8'h14) begin n_fail++; $display("FAIL refused_no_change: got cnt %0d vec %h want 2/14", i0.busy_cnt, i0.busy_vec); end
    i0.wr_en = 1; i0.wr_addr = 2; i0.wr_data = 16'h2222;
    step();
    i0.wr_en = 0; i0.rd_addr_a = 2;
    #1;
    n_chk++; if (i0.busy_a !== 1'b0 || i0.busy_cnt !== 4'd1 || i0.busy_vec !== 8'h10) begin n_fail++; $display("FAIL wb_release: got busy %b cnt %0d vec %h want 0/1/10", i0.busy_a, i0.busy_cnt, i0.busy_vec); end
    i0.rsv_en = 1; i0.rsv_addr = 4; i0.wr_en = 1; i0.wr_addr = 4; i0.wr_data = 16'h4444;
    #1;
    n_chk++; if (i0.rsv_stall !== 1'b0) begin n_fail++; $display("FAIL rsv_wr_same_stall: got %b want 0", i0.rsv_stall); end
    step();
    i0.rsv_en = 0; i0.wr_en = 0; i0.rd_addr_b = 4;
    #1;
    n_chk++; if (i0.busy_b !== 1'b1 || i0.rd_data_b !== 16'h4444 || i0.busy_cnt !== 4'd1) begin n_fail++; $display("FAIL rsv_wr_same: got busy %b data %h cnt %0d want 1/4444/1", i0.busy_b, i0.rd_data_b, i0.busy_cnt); end
    i0.wr_en = 1; i0.wr_addr = 4; i0.wr_data = 16'h4545; i0.rsv_en = 1; i0.rsv_addr = 6;
    step();
    i0.wr_en = 0; i0.rsv_en = 0;
    #1;
    n_chk++; if (i0.busy_vec !== 8'h40 || i0.busy_cnt !== 4'd1 || i0.rd_data_b !== 16'h4545) begin n_fail++; $display("FAIL rsv_wr_diff: got vec %h cnt %0d data %h want 40/1/4545", i0.busy_vec, i0.busy_cnt, i0.rd_data_b); end
  endtask

  task automatic test_zero_r0();
    i2.wr_en = 1; i2.wr_addr = 0; i2.wr_data = 16'hFFFF; i2.rsv_en = 1; i2.rsv_addr = 0;
    i2.rd_addr_a = 0;
    #1;
    n_chk++; if (i2.rsv_stall !== 1'b0 || i2.rd_data_a !== 16'h0) begin n_fail++; $display("FAIL r0_same_cycle: got stall %b data %h want 0/0000", i2.rsv_stall, i2.rd_data_a); end
    step();
    i2.wr_en = 0; i2.rsv_en = 0;
    #1;
    n_chk++; if (i2.rd_data_a !== 16'h0 || i2.busy_a !== 1'b0 || i2.busy_cnt !== 4'd0 || i2.busy_vec !== 8'h00) begin n_fail++; $display("FAIL r0_after: got data %h busy %b cnt %0d vec %h want 0000/0/0/00", i2.rd_data_a, i2.busy_a, i2.busy_cnt, i2.busy_vec); end
    i2.wr_en = 1; i2.wr_addr = 1; i2.wr_data = 16'hBEEF;
    step();
    i2.wr_en = 0; i2.rd_addr_b = 1;
    #1;
    n_chk++; if (i2.rd_data_b !== 16'hBEEF) begin n_fail++; $display("FAIL r0_mode_r1: got %h want beef", i2.rd_data_b); end
  endtask

  task automatic test_async_reset();
    rst = 1; #1; rst = 0;
    i0.wr_en = 1; i0.wr_addr = 1; i0.wr_data = 16'hAAAA; i0.rsv_en = 1; i0.rsv_addr = 1;
    step();
    i0.wr_en = 0; i0.rsv_addr = 3;
    step();
    i0.rsv_addr = 5;
    step();
    i0.rsv_en = 0; i0.rd_addr_a = 1;
    #1;
    n_chk++; if (i0.rd_data_a !== 16'hAAAA || i0.busy_cnt !== 4'd3 || i0.busy_vec !== 8'h2A) begin n_fail++; $display("FAIL pre_reset: got data %h cnt %0d vec %h want aaaa/3/2a", i0.rd_data_a, i0.busy_cnt, i0.busy_vec); end
    rst = 1;
    #1;
    n_chk++; if (i0.rd_data_a !== 16'h0 || i0.busy_a !== 1'b0 || i0.rsv_stall !== 1'b0) begin n_fail++; $display("FAIL async_clear_read: got data %h busy %b stall %b want 0000/0/0", i0.rd_data_a, i0.busy_a, i0.rsv_stall); end
    n_chk++; if (i0.busy_cnt !== 4'd0 || i0.busy_vec !== 8'h00) begin n_fail++; $display("FAIL async_clear_busy: got cnt %0d vec %h want 0/00", i0.busy_cnt, i0.busy_vec); end
    i0.wr_en = 1; i0.wr_addr = 1; i0.wr_data = 16'h5555; i0.rsv_en = 1; i0.rsv_addr = 2;
    step();
    i0.wr_en = 0; i0.rsv_en = 0;
    #1;
    rst = 0;
    #1;
    n_chk++; if (i0.rd_data_a !== 16'h0 || i0.busy_cnt !== 4'd0 || i0.busy_vec !== 8'h00) begin n_fail++; $display("FAIL no_update_in_reset: got data %h cnt %0d vec %h want 0000/0/00", i0.rd_data_a, i0.busy_cnt, i0.busy_vec); end
  endtask

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    quiet();
    test_reset();
    test_write_readback();
    test_bypass();
    test_scoreboard();
    test_zero_r0();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
